dff_pipe: RTL

- Parametrised successor to the single-bit master-slave D flip-flop.
- A chain of DEPTH edge-triggered WIDTH-bit register stages with a valid/ready handshake at each end.
- Stalls per stage, collapses bubbles, and supports synchronous flush.
- Used as the generic pipeline/elastic register between datapath stages of the CPU models; it exposes q and qn outputs as the flip-flop primitive does.

---
 rtl/dff_pipe.sv | 75 +++++++
 1 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage elastic register chain with valid/ready at both ends,
// per-stage stalling with bubble collapse, synchronous flush, and q/qn outputs.
module dff_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  count
);
    logic [DEPTH-1:0] v_q, v_d, src_v;
    logic [WIDTH-1:0] r_q [DEPTH];
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [WIDTH-1:0] src_r [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             in_x, out_x;

    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign src_v[g] = in_valid;
            assign src_r[g] = d;
        end else begin : g_body
            assign src_v[g] = v_q[g-1];
            assign src_r[g] = r_q[g-1];
        end
    end

    // A stage may load when it is empty or the stage ahead is moving.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            rdy[i] = !v_q[i] | rdy[i+1];
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = flush ? 1'b0 : (rdy[i] ? src_v[i] : v_q[i]);
            r_d[i] = (!flush && rdy[i] && src_v[i]) ? src_r[i] : r_q[i];
        end
    end

    assign in_x  = in_valid & rdy[0];
    assign out_x = v_q[DEPTH-1] & out_ready;
    assign cnt_d = flush ? '0 : cnt_q + CNTW'(in_x) - CNTW'(out_x);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_q[i] <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++)
                r_q[i] <= r_d[i];
        end
    end

    assign in_ready  = rdy[0];
    assign q         = r_q[DEPTH-1];
    assign qn        = ~r_q[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign count     = cnt_q;
endmodule
